// File: rtl/fpadd_pkg_40.sv
// rtl/fpadd_pkg_40.sv - shared IEEE-754 single-precision field definitions
//
// Purpose: field widths, the all-ones exponent and small helpers used by
//          the fpadd issue logic.
// Ports:   none (package).
package fpadd_pkg_40;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIGN_BIT = 31;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef logic [31:0] fp32_t;

  // Subtract is done by flipping B's sign; the adder only ever adds.
  function automatic fp32_t flip_sign(input fp32_t v, input logic sub);
    return v ^ {sub, {SIGN_BIT{1'b0}}};
  endfunction

  // True for Inf/NaN encodings (exponent field all ones).
  function automatic logic is_exp_max(input fp32_t v);
    return v[MAN_W +: EXP_W] == EXP_MAX;
  endfunction

endpackage

// File: rtl/fp_issue_fifo_40.sv
// rtl/fp_issue_fifo_40.sv - parameterized synchronous FIFO for operand entries
//
// Purpose: small first-word-fall-through FIFO holding issue entries.
// Ports:   i_clk/i_rst   clock, synchronous active-high reset
//          i_push/i_data write strobe and entry (ignored when full)
//          i_pop         read strobe (ignored when empty)
//          o_data        current head entry
//          o_full/o_empty occupancy flags
module fp_issue_fifo_40 #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/fp_operand_issue_40.sv
// rtl/fp_operand_issue_40.sv - operand issue stage in front of the fpadd core
//
// Purpose: buffers add/sub operand pairs, issues one pair per cycle into the
//          non-stallable adder when a downstream result credit is available,
//          and tracks in-flight operations so results leave with a valid and
//          the caller's tag.
// Ports:   clk_40/rst_40        clock, synchronous active-high reset
//          in_valid/in_ready    operand handshake; in_x, in_y, in_sub, in_tag
//          add_x_40/add_y_40    registered adder operands (B sign pre-flipped)
//          res_40               adder result input
//          res_valid/res_out/res_tag  registered result with aligned tag
//          res_ack              consumer returns one credit
//          busy                 FIFO non-empty or anything in flight
//          res_special          (FPISSUE_SPECIAL_FLAG_EN only) an operand was
//                               Inf/NaN
// Build option: FPISSUE_SPECIAL_FLAG_EN adds res_special.
module fp_operand_issue_40
  import fpadd_pkg_40::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = 4,
  parameter int CREDITS = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk_40,
  input  logic             rst_40,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      add_x_40,
  output logic [31:0]      add_y_40,
  input  logic [31:0]      res_40,
  output logic             res_valid,
  output logic [31:0]      res_out,
  output logic [TAG_W-1:0] res_tag,
  input  logic             res_ack,
`ifdef FPISSUE_SPECIAL_FLAG_EN
  output logic             res_special,
`endif
  output logic             busy
);

`ifdef FPISSUE_SPECIAL_FLAG_EN
  localparam int SP_W = 1;
`else
  localparam int SP_W = 0;
`endif

  // Entry layout (MSB..LSB): [special], x, y_eff, tag
  localparam int EW = 64 + TAG_W + SP_W;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  logic [EW-1:0]    w_enq_data;
  logic [EW-1:0]    w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_issue;
  fp32_t            w_y_eff;
  fp32_t            w_head_x;
  fp32_t            w_head_y;
  logic [TAG_W-1:0] w_head_tag;
  logic [CW-1:0]    w_cred_next;

  logic [CW-1:0]    r_credits;
  logic [31:0]      r_add_x;
  logic [31:0]      r_add_y;
  logic [ADD_LAT:0] r_vld;
  logic [TAG_W-1:0] r_tag [ADD_LAT+1];
  logic [31:0]      r_res_out;

  assign in_ready = ~w_full;
  assign w_enq    = in_valid & in_ready;
  assign w_y_eff  = flip_sign(in_y, in_sub);

`ifdef FPISSUE_SPECIAL_FLAG_EN
  logic             w_enq_special;
  logic             w_head_special;
  logic [ADD_LAT:0] r_spc;

  assign w_enq_special  = is_exp_max(in_x) | is_exp_max(in_y);
  assign w_enq_data     = {w_enq_special, in_x, w_y_eff, in_tag};
  assign w_head_special = w_head[EW-1];
`else
  assign w_enq_data = {in_x, w_y_eff, in_tag};
`endif

  assign w_head_x   = w_head[TAG_W+32 +: 32];
  assign w_head_y   = w_head[TAG_W +: 32];
  assign w_head_tag = w_head[0 +: TAG_W];

  fp_issue_fifo_40 #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_40),
    .i_rst   (rst_40),
    .i_push  (w_enq),
    .i_data  (w_enq_data),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The adder cannot stall, so nothing issues unless a result slot is free.
  assign w_issue = ~w_empty & (r_credits != '0);

  // Issue and ack together cancel; a spurious ack at full credit is dropped.
  always_comb begin
    w_cred_next = r_credits;
    if (w_issue && !res_ack) begin
      w_cred_next = r_credits - CRED_ONE;
    end else if (!w_issue && res_ack && (r_credits != CRED_MAX)) begin
      w_cred_next = r_credits + CRED_ONE;
    end
  end

  always_ff @(posedge clk_40) begin
    if (rst_40) begin
      r_credits <= CRED_MAX;
    end else begin
      r_credits <= w_cred_next;
    end
  end

  // Operand registers hold during bubbles; the valid line marks the bubble.
  // Tags shift only behind a valid bit so res_tag holds with res_out.
  always_ff @(posedge clk_40) begin
    if (rst_40) begin
      r_add_x   <= '0;
      r_add_y   <= '0;
      r_vld     <= '0;
      r_res_out <= '0;
      for (int k = 0; k <= ADD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_vld <= {r_vld[ADD_LAT-1:0], w_issue};
      if (w_issue) begin
        r_add_x  <= w_head_x;
        r_add_y  <= w_head_y;
        r_tag[0] <= w_head_tag;
      end
      for (int k = 1; k <= ADD_LAT; k++) begin
        if (r_vld[k-1]) r_tag[k] <= r_tag[k-1];
      end
      // res_40 belongs to the op in the second-to-last stage this cycle.
      if (r_vld[ADD_LAT-1]) r_res_out <= res_40;
    end
  end

`ifdef FPISSUE_SPECIAL_FLAG_EN
  always_ff @(posedge clk_40) begin
    if (rst_40) begin
      r_spc <= '0;
    end else begin
      r_spc <= {r_spc[ADD_LAT-1:0], w_issue & w_head_special};
    end
  end

  assign res_special = r_spc[ADD_LAT];
`endif

  assign add_x_40  = r_add_x;
  assign add_y_40  = r_add_y;
  assign res_valid = r_vld[ADD_LAT];
  assign res_tag   = r_tag[ADD_LAT];
  assign res_out   = r_res_out;
  assign busy      = ~w_empty | (|r_vld);

endmodule

// File: tb/tb_fp_operand_issue_40.sv
// tb/tb_fp_operand_issue_40.sv - scoreboard bench for fp_operand_issue_40
module tb_fp_operand_issue_40;

  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 4;
  localparam int CREDITS = 4;
  localparam int TAG_W   = 4;

  logic        clk_40 = 1'b0;
  logic        rst_40 = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [31:0] add_x_40;
  logic [31:0] add_y_40;
  logic [31:0] res_40;
  logic        res_valid;
  logic [31:0] res_out;
  logic [3:0]  res_tag;
  logic        busy;
  logic        man_ack = 1'b0;
  logic        auto_ack_q = 1'b0;
  logic        auto_ack = 1'b0;
`ifdef FPISSUE_SPECIAL_FLAG_EN
  logic        res_special;
`endif

  always #5 clk_40 = ~clk_40;

  fp_operand_issue_40 #(
    .DEPTH   (DEPTH),
    .ADD_LAT (ADD_LAT),
    .CREDITS (CREDITS),
    .TAG_W   (TAG_W)
  ) dut (
    .clk_40    (clk_40),
    .rst_40    (rst_40),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .add_x_40  (add_x_40),
    .add_y_40  (add_y_40),
    .res_40    (res_40),
    .res_valid (res_valid),
    .res_out   (res_out),
    .res_tag   (res_tag),
    .res_ack   (man_ack | auto_ack_q),
`ifdef FPISSUE_SPECIAL_FLAG_EN
    .res_special (res_special),
`endif
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int res_cnt = 0;
  int ack_cnt = 0;
  int res_cyc[$];

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in adder: a few real sums, a scrambling function otherwise.
  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  // Adder pipeline model whose output lines up with the second-to-last
  // delay-line stage of the issue block.
  logic [31:0] pipe [ADD_LAT-1];
  always @(posedge clk_40) begin
    pipe[0] <= model_add(add_x_40, add_y_40);
    for (int k = 1; k < ADD_LAT-1; k++) pipe[k] <= pipe[k-1];
  end
  assign res_40 = pipe[ADD_LAT-2];

  always @(posedge clk_40) cyc <= cyc + 1;

  // Result monitor: pops the scoreboard and optionally acks each result.
  always @(negedge clk_40) begin
    exp_t e;
    auto_ack_q = 1'b0;
    if (res_valid) begin
      res_cnt++;
      res_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("res_out", res_out, e.res);
        check("res_tag", 32'(res_tag), 32'(e.tag));
      end
      if (auto_ack) begin
        auto_ack_q = 1'b1;
        ack_cnt++;
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic sub, input logic [3:0] tag);
    logic acc;
    acc = 1'b0;
    in_x = x; in_y = y; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_40);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) sb.push_back({model_add(x, y ^ {sub, 31'b0}), tag});
    else in_valid = 1'b0;
    @(posedge clk_40); #1;
    check("send_accept", 32'(acc), 32'd1);
  endtask

  // Waits for all results, returning owed credits one per cycle.
  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk_40); #1;
      man_ack = 1'b0;
      if (sb.size() == 0 && !busy && res_cnt == ack_cnt) begin
        done = 1'b1;
        break;
      end
      if (res_cnt > ack_cnt) begin
        man_ack = 1'b1;
        ack_cnt++;
      end
    end
    man_ack = 1'b0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a_edge;
    int k_edge;
    int lat;

    repeat (3) @(posedge clk_40);
    #1 rst_40 = 1'b0;
    @(negedge clk_40);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_out", res_out, 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_x", add_x_40, 32'd0);
    check("rst_add_y", add_y_40, 32'd0);
    @(posedge clk_40); #1;

    // Single add with latency measurement
    auto_ack = 1'b1;
    res_cyc.delete();
    send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5);
    in_valid = 1'b0;
    a_edge = cyc;
    @(posedge clk_40); #1;
    check("add_x_single", add_x_40, 32'h3F80_0000);
    check("add_y_single", add_y_40, 32'h4000_0000);
    drain();
    lat = (res_cyc.size() > 0) ? res_cyc[0] - a_edge : -1;
    check("single_latency", 32'(lat), 32'(ADD_LAT + 1));

    // Subtract flips B's sign
    send(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd6);
    in_valid = 1'b0;
    @(posedge clk_40); #1;
    check("add_x_sub", add_x_40, 32'h4040_0000);
    check("add_y_sub", add_y_40, 32'hBF80_0000);
    drain();

    // Credit stall: 6 offered, 4 issue without acks
    auto_ack = 1'b0;
    res_cyc.delete();
    for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
    in_valid = 1'b0;
    repeat (12) @(posedge clk_40); #1;
    check("stall_issued", 32'(res_cyc.size()), 32'd4);
    check("stall_busy", 32'(busy), 32'd1);
    man_ack = 1'b1;
    ack_cnt++;
    k_edge = cyc + 1;
    @(posedge clk_40); #1;
    man_ack = 1'b0;
    repeat (10) @(posedge clk_40); #1;
    check("stall_after_ack", 32'(res_cyc.size()), 32'd5);
    lat = (res_cyc.size() > 4) ? res_cyc[4] - k_edge : -1;
    check("stall_ack_latency", 32'(lat), 32'(ADD_LAT + 1));
    drain();

    // FIFO full with zero credits; ack plus issue in the same cycle
    res_cyc.delete();
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
    in_valid = 1'b0;
    @(negedge clk_40);
    check("full_in_ready", 32'(in_ready), 32'd0);
    repeat (10) @(posedge clk_40); #1;
    check("full_first_results", 32'(res_cyc.size()), 32'd4);
    check("full_still_full", 32'(in_ready), 32'd0);
    man_ack = 1'b1;
    ack_cnt++;
    @(posedge clk_40); #1;
    ack_cnt++;
    @(negedge clk_40);
    check("full_hold", 32'(in_ready), 32'd0);
    @(posedge clk_40); #1;
    man_ack = 1'b0;
    @(negedge clk_40);
    check("full_rise", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk_40); #1;
    check("full_issue_ack_count", 32'(res_cyc.size()), 32'd6);
    drain();

    // Back-to-back with an ack per result
    auto_ack = 1'b1;
    res_cyc.delete();
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i));
    in_valid = 1'b0;
    drain();
    check("b2b_count", 32'(res_cyc.size()), 32'd8);
    for (int k = 1; k < CREDITS; k++) begin
      lat = (res_cyc.size() > k) ? res_cyc[k] - res_cyc[k-1] : -1;
      check("b2b_gap", 32'(lat), 32'd1);
    end

    // Reset with three operations in flight
    auto_ack = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 4'(9 + i));
    in_valid = 1'b0;
    @(posedge clk_40); #1;
    rst_40 = 1'b1;
    @(posedge clk_40); #1;
    rst_40 = 1'b0;
    sb.delete();
    res_cyc.delete();
    res_cnt = 0;
    ack_cnt = 0;
    for (int k = 0; k < ADD_LAT + 2; k++) begin
      @(negedge clk_40);
      check("midrst_res_valid", 32'(res_valid), 32'd0);
    end
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk_40); #1;
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 1'b0, 4'(i));
    in_valid = 1'b0;
    repeat (12) @(posedge clk_40); #1;
    check("midrst_credits", 32'(res_cyc.size()), 32'(CREDITS));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
